scr_64b66b_lane: RTL and testbench
==================================

Name: scr_64b66b_lane

Overview:
- 10GBASE-R style self-synchronizing scrambler/descrambler lane pair, polynomial G(x)=1+x^39+x^58.
- TX path scrambles the 64b/66b block payload before the gearbox; RX path descrambles after block lock.
- Both paths process LEN bits per clock, serial order LSB first, with one enable each.
- Scrambled TX output looped into RX input reproduces the TX data from the first valid word after reset.

Parameters:
- LEN, 32, payload bits per clock; legal values 8, 16, 32, 64 (must divide 64).

Ports:
- clk  in  1  single clock, rising edge.
- nreset  in  1  asynchronous reset, active-high: asserted 1 resets, 0 runs.
- tx_valid_i  in  1  TX word valid; the TX LFSR advances only when high.
- tx_data_i  in  LEN  TX plain payload, bit 0 transmitted first.
- tx_scram_o  out  LEN  TX scrambled payload, combinational.
- rx_valid_i  in  1  RX word valid; the RX LFSR advances only when high.
- rx_scram_i  in  LEN  RX scrambled payload.
- rx_data_o  out  LEN  RX descrambled payload, combinational.

Behaviour:
- State: two independent 58-bit registers, tx_s and rx_s; s[0] is the most recently sent or received scrambled bit.
- Reset: both registers load all ones (58'h3FF_FFFF_FFFF_FFFF) asynchronously while nreset=1. Mid-operation reset discards history immediately.
- TX serial definition, for i=0..LEN-1 in order: o[i] = d[i] ^ h(i-39) ^ h(i-58).
  - h(k) is o[k] when k>=0 (same word), else the tx_s history bit |k|-1 back.
  - LEN=64 therefore chains bits 39..63 on same-word outputs. This is combinational; no extra cycle.
- RX: d[i] = c[i] ^ h(i-39) ^ h(i-58), with h taken over received scrambled bits c. No in-word chaining dependency on outputs.
- Latency: zero. Outputs are combinational from the current input and state; there are no output registers.
- Update: on a clk rising edge with valid=1, shift the LEN new scrambled bits into state. Use tx_scram_o for TX and rx_scram_i for RX. The newest bit (bit LEN-1) becomes s[0].
- valid=0: state holds. Outputs still reflect the current input XOR the held state.
- Because reset is all ones, the first TX word out of reset equals the input on bits 0..38.
- RX self-synchronizes: after 58 valid error-free bits, rx_data_o is correct regardless of the initial rx_s.
- A single-bit channel error corrupts exactly 3 output bits: offsets 0, +39, +58.
- The TX and RX valids are independent. Simultaneous valid on both paths has no interaction.

Optional Feature:
- Macro SCRAM_BYPASS_EN adds input port bypass_i (1 bit).
- With the macro defined and bypass_i=1: tx_scram_o=tx_data_i and rx_data_o=rx_scram_i. State still shifts the line-side bits on valid, so removing bypass resumes correctly.
- Without the macro: the port does not exist and the path always scrambles.

Decomposition:
- Package scr_64b66b_pkg holds:
  - SCR_STATE_W=58;
  - tap constants SCR_TAP_A=39 and SCR_TAP_B=58;
  - SCR_RST_STATE (all ones);
  - typedef scr_state_t (logic [57:0]).
- One sub-module, scr_64b66b_core (parameter LEN, DIR=TX/RX), instantiated twice. It contains the state register, XOR network and shift update.

Test Plan:
- Reset, LEN=32, tx_valid=1; drive 32'h0000001e then 32'h00000000 -> tx_scram_o 32'h0000001e then 32'h7bfff080.
- LEN=64, reset, drive 64'h1e -> tx_scram_o 64'h7bfff0800000001e in the same cycle.
- Loopback tx_scram_o->rx_scram_i, shared valid, 100 random words after reset -> rx_data_o == tx_data_i every cycle.
- valid=0 for 5 cycles with changing data, then resume the known vector -> the second word is still 32'h7bfff080 (state held).
- Preload RX with 2 garbage words while TX is reset, then loop back -> mismatches end after the first 58 bits; all words thereafter match.
- Assert nreset mid-stream on both paths, release, repeat the first vector -> identical outputs 32'h0000001e, 32'h7bfff080.

Source files
------------

// File: rtl/scr_64b66b_pkg.sv
// Shared constants and types for the 64b/66b self-synchronizing scrambler, G(x)=1+x^39+x^58.
package scr_64b66b_pkg;

   localparam int unsigned SCR_STATE_W = 58;
   localparam int unsigned SCR_TAP_A   = 39;
   localparam int unsigned SCR_TAP_B   = 58;

   typedef logic [SCR_STATE_W-1:0] scr_state_t;

   localparam scr_state_t SCR_RST_STATE = 58'h3FF_FFFF_FFFF_FFFF;

   typedef enum logic {
      SCR_DIR_TX = 1'b0,
      SCR_DIR_RX = 1'b1
   } scr_dir_t;

endpackage

// File: rtl/scr_64b66b_core.sv
// One scrambler (TX) or descrambler (RX) path: 58-bit line history, XOR network and shift update.
module scr_64b66b_core
   import scr_64b66b_pkg::*;
#(
   parameter int unsigned LEN = 32,
   parameter scr_dir_t    DIR = SCR_DIR_TX
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid,
   input  logic           bypass,
   input  logic [LEN-1:0] din,
   output logic [LEN-1:0] dout_c
);

   localparam int unsigned EXT_W = SCR_STATE_W + LEN;
   localparam int unsigned OFS_A = SCR_STATE_W - SCR_TAP_A;
   localparam int unsigned OFS_B = SCR_STATE_W - SCR_TAP_B;

   scr_state_t       state_q;
   scr_state_t       state_d;
   logic [EXT_W-1:0] line_ext;
   logic [LEN-1:0]   scr_c;

   // Line stream in time order: oldest history bit at index 0, this word's bits on top.
   // TX feeds its own outputs back in, which gives the in-word chaining for LEN > 39.
   always_comb begin
      line_ext = '0;
      scr_c    = '0;
      state_d  = state_q;
      for (int m = 0; m < int'(SCR_STATE_W); m++) begin
         line_ext[int'(SCR_STATE_W) - 1 - m] = state_q[m];
      end
      for (int i = 0; i < int'(LEN); i++) begin
         scr_c[i] = din[i] ^ line_ext[i + int'(OFS_A)] ^ line_ext[i + int'(OFS_B)];
         if (DIR == SCR_DIR_TX) begin
            line_ext[int'(SCR_STATE_W) + i] = bypass ? din[i] : scr_c[i];
         end else begin
            line_ext[int'(SCR_STATE_W) + i] = din[i];
         end
      end
      for (int m = 0; m < int'(SCR_STATE_W); m++) begin
         state_d[m] = line_ext[int'(EXT_W) - 1 - m];
      end
   end

   assign dout_c = bypass ? din : scr_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SCR_RST_STATE;
      end else if (valid) begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/scr_64b66b_lane.sv
// 10GBASE-R scrambler/descrambler lane pair with independent TX and RX enables.
// Define SCRAM_BYPASS_EN to add bypass_i, which passes data through while history keeps tracking the line.
module scr_64b66b_lane
   import scr_64b66b_pkg::*;
#(
   parameter int unsigned LEN = 32
) (
   input  logic           clk,
   input  logic           nreset,
`ifdef SCRAM_BYPASS_EN
   input  logic           bypass_i,
`endif
   input  logic           tx_valid_i,
   input  logic [LEN-1:0] tx_data_i,
   output logic [LEN-1:0] tx_scram_o,
   input  logic           rx_valid_i,
   input  logic [LEN-1:0] rx_scram_i,
   output logic [LEN-1:0] rx_data_o
);

   logic bypass;

`ifdef SCRAM_BYPASS_EN
   assign bypass = bypass_i;
`else
   assign bypass = 1'b0;
`endif

   scr_64b66b_core #(
      .LEN (LEN),
      .DIR (SCR_DIR_TX)
   ) u_tx (
      .clk    (clk),
      .rst    (nreset),
      .valid  (tx_valid_i),
      .bypass (bypass),
      .din    (tx_data_i),
      .dout_c (tx_scram_o)
   );

   scr_64b66b_core #(
      .LEN (LEN),
      .DIR (SCR_DIR_RX)
   ) u_rx (
      .clk    (clk),
      .rst    (nreset),
      .valid  (rx_valid_i),
      .bypass (bypass),
      .din    (rx_scram_i),
      .dout_c (rx_data_o)
   );

endmodule

// File: tb/tb_scr_64b66b_lane.sv
// Bench for scr_64b66b_lane: LEN=32 and LEN=64 lanes against a bit-serial line-stream reference.
module tb_scr_64b66b_lane;

   logic        clk;
   logic        nreset;
   logic        tx_valid, rx_valid, loop32;
   logic [31:0] tx_data32, tx_scram32, rx_drv32, rx_scram32, rx_data32;
   logic        valid64;
   logic [63:0] tx_data64, tx_scram64, rx_data64;

   int checks = 0;
   int errors = 0;

   // hist[0]=tx32, [1]=rx32, [2]=tx64, [3]=rx64 : line bits in time order, newest last
   bit hist[4][$];

   logic [31:0] o, r, d;
   logic [63:0] o64, r64, d64;
   bit          v;

   assign rx_scram32 = loop32 ? tx_scram32 : rx_drv32;

   scr_64b66b_lane #(.LEN(32)) u_dut32 (
      .clk        (clk),
      .nreset     (nreset),
`ifdef SCRAM_BYPASS_EN
      .bypass_i   (1'b0),
`endif
      .tx_valid_i (tx_valid),
      .tx_data_i  (tx_data32),
      .tx_scram_o (tx_scram32),
      .rx_valid_i (rx_valid),
      .rx_scram_i (rx_scram32),
      .rx_data_o  (rx_data32)
   );

   scr_64b66b_lane #(.LEN(64)) u_dut64 (
      .clk        (clk),
      .nreset     (nreset),
`ifdef SCRAM_BYPASS_EN
      .bypass_i   (1'b0),
`endif
      .tx_valid_i (valid64),
      .tx_data_i  (tx_data64),
      .tx_scram_o (tx_scram64),
      .rx_valid_i (valid64),
      .rx_scram_i (tx_scram64),
      .rx_data_o  (rx_data64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int p = 0; p < 4; p++) begin
         hist[p].delete();
         for (int k = 0; k < 58; k++) hist[p].push_back(1'b1);
      end
   endtask

   // Serial rule: out = in ^ line[n-39] ^ line[n-58]; TX line is its output, RX line is its input.
   task automatic model_word(input int p, input logic [63:0] din, input int len,
                             input bit is_tx, input bit commit, output logic [63:0] dout);
      bit h[$];
      bit a, b, ob;
      h = hist[p];
      dout = '0;
      for (int i = 0; i < len; i++) begin
         a = h[h.size() - 39];
         b = h[h.size() - 58];
         ob = din[i] ^ a ^ b;
         dout[i] = ob;
         h.push_back(is_tx ? ob : din[i]);
      end
      if (commit) begin
         while (h.size() > 58) h.delete(0);
         hist[p] = h;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_pulse();
      nreset = 1'b1;
      model_reset();
      #1;
      nreset = 1'b0;
   endtask

   task automatic cycle32(input logic [31:0] td, input bit tv, input bit rv,
                          input logic [31:0] rd, input bit lp,
                          output logic [31:0] otx, output logic [31:0] orx);
      logic [63:0] etx, erx, rin;
      tx_valid = tv; tx_data32 = td; rx_valid = rv; rx_drv32 = rd; loop32 = lp;
      #1;
      model_word(0, {32'h0, td}, 32, 1'b1, tv && !nreset, etx);
      rin = lp ? etx : {32'h0, rd};
      model_word(1, rin, 32, 1'b0, rv && !nreset, erx);
      check("tx32_model", 64'(tx_scram32), etx);
      check("rx32_model", 64'(rx_data32), erx);
      otx = tx_scram32;
      orx = rx_data32;
      @(negedge clk);
   endtask

   task automatic cycle64(input logic [63:0] td, input bit vv,
                          output logic [63:0] otx, output logic [63:0] orx);
      logic [63:0] etx, erx;
      valid64 = vv; tx_data64 = td;
      #1;
      model_word(2, td, 64, 1'b1, vv && !nreset, etx);
      model_word(3, etx, 64, 1'b0, vv && !nreset, erx);
      check("tx64_model", tx_scram64, etx);
      check("rx64_model", rx_data64, erx);
      otx = tx_scram64;
      orx = rx_data64;
      @(negedge clk);
   endtask

   initial begin
      nreset = 1'b1;
      tx_valid = 1'b0; rx_valid = 1'b0; loop32 = 1'b0;
      tx_data32 = '0; rx_drv32 = '0;
      valid64 = 1'b0; tx_data64 = '0;
      model_reset();
      @(negedge clk);

      // Held in reset: all-ones history cancels both taps, valid is ignored
      cycle32(32'h1e, 1'b1, 1'b1, 32'h0, 1'b0, o, r);
      check("rst_tx", 64'(o), 64'h1e);
      check("rst_rx", 64'(r), 64'h0);

      // Known vector out of reset
      nreset = 1'b0;
      cycle32(32'h1e, 1'b1, 1'b0, 32'h0, 1'b0, o, r);
      check("vec_w0", 64'(o), 64'h1e);
      cycle32(32'h0, 1'b1, 1'b0, 32'h0, 1'b0, o, r);
      check("vec_w1", 64'(o), 64'h7bfff080);

      // LEN=64 chains bits 39..63 on same-word outputs
      reset_pulse();
      cycle64(64'h1e, 1'b1, o64, r64);
      check("vec64_tx", o64, 64'h7bfff0800000001e);
      check("vec64_rx", r64, 64'h1e);
      for (int k = 0; k < 20; k++) begin
         d64 = {$urandom, $urandom};
         v = ($urandom_range(0, 3) != 0);
         cycle64(d64, v, o64, r64);
         check("loop64", r64, d64);
      end

      // Loopback with shared, randomly gated valid
      reset_pulse();
      for (int k = 0; k < 100; k++) begin
         d = $urandom;
         v = ($urandom_range(0, 3) != 0);
         cycle32(d, v, v, 32'h0, 1'b1, o, r);
         check("loop32", 64'(r), 64'(d));
      end

      // valid low holds state while outputs follow changing data
      reset_pulse();
      cycle32(32'h1e, 1'b1, 1'b0, 32'h0, 1'b0, o, r);
      for (int k = 0; k < 5; k++) cycle32($urandom, 1'b0, 1'b0, 32'h0, 1'b0, o, r);
      cycle32(32'h0, 1'b1, 1'b0, 32'h0, 1'b0, o, r);
      check("hold_w1", 64'(o), 64'h7bfff080);

      // RX preloaded with garbage, then self-synchronizes after 58 line bits
      reset_pulse();
      for (int k = 0; k < 2; k++) cycle32(32'h0, 1'b0, 1'b1, $urandom, 1'b0, o, r);
      for (int k = 0; k < 10; k++) begin
         d = $urandom;
         cycle32(d, 1'b1, 1'b1, 32'h0, 1'b1, o, r);
         if (k == 1) check("sync_w1_hi", 64'((r ^ d) & 32'hfc00_0000), 64'h0);
         if (k >= 2) check("sync_match", 64'(r), 64'(d));
      end

      // Mid-stream reset discards history at once
      reset_pulse();
      for (int k = 0; k < 3; k++) cycle32($urandom, 1'b1, 1'b1, 32'h0, 1'b1, o, r);
      #2;
      nreset = 1'b1;
      model_reset();
      cycle32(32'h1e, 1'b1, 1'b1, 32'h0, 1'b1, o, r);
      check("mid_rst_tx", 64'(o), 64'h1e);
      nreset = 1'b0;
      cycle32(32'h1e, 1'b1, 1'b1, 32'h0, 1'b1, o, r);
      check("mid_w0", 64'(o), 64'h1e);
      check("mid_w0_rx", 64'(r), 64'h1e);
      cycle32(32'h0, 1'b1, 1'b1, 32'h0, 1'b1, o, r);
      check("mid_w1", 64'(o), 64'h7bfff080);
      check("mid_w1_rx", 64'(r), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
